// File: rtl/rv_alu_r_arb_if.sv
// Request/response bundle for the shared R-type ALU.
// master = requesters + consumer, slave = arbiter.
interface rv_alu_r_arb_if #(
  parameter int TAG_W = 5
) ();
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [63:0]        req_rs1;
  logic [63:0]        req_rs2;
  logic [5:0]         req_funct3;
  logic [1:0]         req_funct7_r;
  logic [2*TAG_W-1:0] req_tag;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_src;
  logic [TAG_W-1:0]   resp_tag;
  logic [31:0]        resp_rd;
  logic               resp_illegal;

  modport master (
    output req_valid, req_rs1, req_rs2,
    output req_funct3, req_funct7_r, req_tag,
    output resp_ready,
    input  req_ready, resp_valid, resp_src,
    input  resp_tag, resp_rd, resp_illegal
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2,
    input  req_funct3, req_funct7_r, req_tag,
    input  resp_ready,
    output req_ready, resp_valid, resp_src,
    output resp_tag, resp_rd, resp_illegal
  );
endinterface

// File: rtl/rv_alu_r_arb.sv
// Two-requester round-robin wrapper around one R-type ALU.
// Grant counters built only with RV_ALU_R_ARB_STATS_EN.
module rv_alu_r (
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7_r,
  output logic [31:0] rd,
  output logic        illegal
);
  // decode {funct7[5],funct3}; unknown ops give rd=0
  always_comb begin
    rd      = '0;
    illegal = 1'b0;
    case ({funct7_r, funct3})
      4'b0000: rd = rs1 + rs2;
      4'b1000: rd = rs1 - rs2;
      4'b0001: rd = rs1 << rs2[4:0];
      4'b0010: rd = {31'b0, $signed(rs1) < $signed(rs2)};
      4'b0011: rd = {31'b0, rs1 < rs2};
      4'b0100: rd = rs1 ^ rs2;
      4'b0101: rd = rs1 >> rs2[4:0];
      4'b1101: rd = $unsigned($signed(rs1) >>> rs2[4:0]);
      4'b0110: rd = rs1 | rs2;
      4'b0111: rd = rs1 & rs2;
      default: illegal = 1'b1;
    endcase
  end
endmodule

module rv_alu_r_arb #(
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
`ifdef RV_ALU_R_ARB_STATS_EN
  output logic [31:0]       stat_grant0,
  output logic [31:0]       stat_grant1,
`endif
  rv_alu_r_arb_if.slave     bus
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state_q, state_d;
  logic               rr_q, rr_d;
  logic               src_q, src_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]        rd_q, rd_d;
  logic               ill_q, ill_d;

  logic               slot_free;
  logic [1:0]         gnt;
  logic               gsel;
  logic [31:0]        op_rs1, op_rs2;
  logic [2:0]         op_f3;
  logic               op_f7r;
  logic [TAG_W-1:0]   op_tag;
  logic [31:0]        alu_rd;
  logic               alu_ill;

  // round-robin grant, only when the result slot can take data
  always_comb begin
    slot_free = (state_q == EMPTY) | bus.resp_ready;
    gnt       = 2'b00;
    if (slot_free) begin
      case (bus.req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    gsel = gnt[1];
  end

  // operand mux from the granted requester
  always_comb begin
    op_rs1 = gsel ? bus.req_rs1[63:32] : bus.req_rs1[31:0];
    op_rs2 = gsel ? bus.req_rs2[63:32] : bus.req_rs2[31:0];
    op_f3  = gsel ? bus.req_funct3[5:3] : bus.req_funct3[2:0];
    op_f7r = bus.req_funct7_r[gsel];
    op_tag = gsel ? bus.req_tag[2*TAG_W-1:TAG_W]
                  : bus.req_tag[TAG_W-1:0];
  end

  rv_alu_r u_alu (
    .rs1      (op_rs1),
    .rs2      (op_rs2),
    .funct3   (op_f3),
    .funct7_r (op_f7r),
    .rd       (alu_rd),
    .illegal  (alu_ill)
  );

  // result slot: load on grant, drain on resp_ready
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    src_d   = src_q;
    tag_d   = tag_q;
    rd_d    = rd_q;
    ill_d   = ill_q;
    if (|gnt) begin
      state_d = FULL;
      rr_d    = ~gsel;
      src_d   = gsel;
      tag_d   = op_tag;
      rd_d    = alu_rd;
      ill_d   = alu_ill;
    end else if (bus.resp_ready) begin
      state_d = EMPTY;
    end
  end

  // slot and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      rr_q    <= 1'b0;
      src_q   <= 1'b0;
      tag_q   <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
      tag_q   <= tag_d;
      rd_q    <= rd_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.req_ready    = gnt;
  assign bus.resp_valid   = (state_q == FULL);
  assign bus.resp_src     = src_q;
  assign bus.resp_tag     = tag_q;
  assign bus.resp_rd      = rd_q;
  assign bus.resp_illegal = ill_q;

`ifdef RV_ALU_R_ARB_STATS_EN
  logic [31:0] cnt0_q, cnt0_d;
  logic [31:0] cnt1_q, cnt1_d;

  // saturating per-requester grant counts
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt[0] && cnt0_q != 32'hFFFF_FFFF) cnt0_d = cnt0_q + 32'd1;
    if (gnt[1] && cnt1_q != 32'hFFFF_FFFF) cnt1_d = cnt1_q + 32'd1;
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign stat_grant0 = cnt0_q;
  assign stat_grant1 = cnt1_q;
`endif
endmodule

// File: tb/tb_rv_alu_r_arb.sv
// Directed bench for rv_alu_r_arb: vector table
// plus arbitration, backpressure and reset sequences.
module tb_rv_alu_r_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rv_alu_r_arb_if #(.TAG_W(5)) bus ();

`ifdef RV_ALU_R_ARB_STATS_EN
  logic [31:0] stat_grant0, stat_grant1;
`endif

  rv_alu_r_arb #(.TAG_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef RV_ALU_R_ARB_STATS_EN
    .stat_grant0 (stat_grant0),
    .stat_grant1 (stat_grant1),
`endif
    .bus         (bus)
  );

  typedef struct {
    logic        src;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic        f7r;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] f3,
                         input logic f7r, input logic [4:0] tag);
    bus.req_rs1[idx*32 +: 32]  = a;
    bus.req_rs2[idx*32 +: 32]  = b;
    bus.req_funct3[idx*3 +: 3] = f3;
    bus.req_funct7_r[idx]      = f7r;
    bus.req_tag[idx*5 +: 5]    = tag;
    bus.req_valid[idx]         = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_valid  = 2'b00;
    bus.resp_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_op(input int idx, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] f3,
                       input logic f7r, input logic [4:0] tag,
                       input logic [31:0] exp_rd, input logic exp_ill,
                       input string nm);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    bus.req_valid  = 2'b00;
    set_req(idx, a, b, f3, f7r, tag);
    #1;
    chk({nm, ".req_ready"}, 32'(bus.req_ready), 32'(2'b01 << idx));
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    chk({nm, ".valid"}, 32'(bus.resp_valid), 32'd1);
    chk({nm, ".rd"}, bus.resp_rd, exp_rd);
    chk({nm, ".src"}, 32'(bus.resp_src), 32'(idx));
    chk({nm, ".tag"}, 32'(bus.resp_tag), 32'(tag));
    chk({nm, ".illegal"}, 32'(bus.resp_illegal), 32'(exp_ill));
  endtask

  initial begin
    bus.req_valid    = 2'b00;
    bus.req_rs1      = '0;
    bus.req_rs2      = '0;
    bus.req_funct3   = '0;
    bus.req_funct7_r = '0;
    bus.req_tag      = '0;
    bus.resp_ready   = 1'b1;

    vecs[0]  = '{1'b0, 32'd5, 32'd7, 3'b000, 1'b0, 32'd12, 1'b0};
    vecs[1]  = '{1'b1, 32'd10, 32'd3, 3'b000, 1'b1, 32'd7, 1'b0};
    vecs[2]  = '{1'b0, 32'h8000_0000, 32'd4, 3'b101, 1'b1,
                 32'hF800_0000, 1'b0};
    vecs[3]  = '{1'b1, 32'hFFFF_FFFF, 32'd1, 3'b010, 1'b0, 32'd1, 1'b0};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 32'd1, 3'b011, 1'b0, 32'd0, 1'b0};
    vecs[5]  = '{1'b1, 32'd1, 32'd33, 3'b001, 1'b0, 32'd2, 1'b0};
    vecs[6]  = '{1'b0, 32'h8000_0000, 32'd4, 3'b101, 1'b0,
                 32'h0800_0000, 1'b0};
    vecs[7]  = '{1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 1'b0,
                 32'h0FF0_0FF0, 1'b0};
    vecs[8]  = '{1'b0, 32'h1234_0000, 32'h0000_5678, 3'b110, 1'b0,
                 32'h1234_5678, 1'b0};
    vecs[9]  = '{1'b1, 32'hFFFF_0000, 32'h1234_5678, 3'b111, 1'b0,
                 32'h1234_0000, 1'b0};
    vecs[10] = '{1'b0, 32'd9, 32'd9, 3'b001, 1'b1, 32'd0, 1'b1};
    vecs[11] = '{1'b1, 32'hFFFF_FFFF, 32'd2, 3'b000, 1'b0, 32'd1, 1'b0};
    vecs[12] = '{1'b0, 32'd0, 32'd1, 3'b000, 1'b1, 32'hFFFF_FFFF, 1'b0};

    do_reset();
    #1;
    chk("rst.valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.src", 32'(bus.resp_src), 32'd0);
    chk("rst.tag", 32'(bus.resp_tag), 32'd0);
    chk("rst.rd", bus.resp_rd, 32'd0);
    chk("rst.illegal", 32'(bus.resp_illegal), 32'd0);
    chk("rst.req_ready", 32'(bus.req_ready), 32'd0);

    for (int i = 0; i < 13; i++) begin
      do_op(int'(vecs[i].src), vecs[i].rs1, vecs[i].rs2, vecs[i].f3,
            vecs[i].f7r, 5'(i + 3), vecs[i].exp_rd, vecs[i].exp_ill,
            $sformatf("vec%0d", i));
    end

    // both valid from reset: req0 first, then req1 back-to-back
    do_reset();
    set_req(0, 32'd10, 32'd3, 3'b000, 1'b1, 5'd1);
    set_req(1, 32'h8000_0000, 32'd4, 3'b101, 1'b1, 5'd2);
    #1;
    chk("rr.first_ready", 32'(bus.req_ready), 32'b01);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    chk("rr.rd0", bus.resp_rd, 32'd7);
    chk("rr.src0", 32'(bus.resp_src), 32'd0);
    chk("rr.tag0", 32'(bus.resp_tag), 32'd1);
    chk("rr.second_ready", 32'(bus.req_ready), 32'b10);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    chk("rr.valid1", 32'(bus.resp_valid), 32'd1);
    chk("rr.rd1", bus.resp_rd, 32'hF800_0000);
    chk("rr.src1", 32'(bus.resp_src), 32'd1);
    chk("rr.tag1", 32'(bus.resp_tag), 32'd2);
    @(posedge clk);
    #1;
    chk("rr.drained", 32'(bus.resp_valid), 32'd0);

    // backpressure: result held 4 cycles, no new accept
    @(negedge clk);
    bus.resp_ready = 1'b0;
    set_req(0, 32'd1, 32'd2, 3'b000, 1'b0, 5'd4);
    #1;
    chk("bp.accept", 32'(bus.req_ready), 32'b01);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    set_req(1, 32'd3, 32'd5, 3'b100, 1'b0, 5'd5);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("bp.hold%0d.ready", c), 32'(bus.req_ready), 32'd0);
      chk($sformatf("bp.hold%0d.valid", c), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("bp.hold%0d.rd", c), bus.resp_rd, 32'd3);
      chk($sformatf("bp.hold%0d.tag", c), 32'(bus.resp_tag), 32'd4);
      chk($sformatf("bp.hold%0d.src", c), 32'(bus.resp_src), 32'd0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(bus.req_ready), 32'b10);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    chk("bp.next.rd", bus.resp_rd, 32'd6);
    chk("bp.next.src", 32'(bus.resp_src), 32'd1);
    chk("bp.next.tag", 32'(bus.resp_tag), 32'd5);

    // illegal op still takes a grant and moves the pointer
    do_reset();
    set_req(0, 32'd9, 32'd9, 3'b001, 1'b1, 5'd7);
    set_req(1, 32'd2, 32'd2, 3'b000, 1'b0, 5'd8);
    #1;
    chk("ill.ready", 32'(bus.req_ready), 32'b01);
    @(posedge clk);
    #1;
    set_req(0, 32'd1, 32'd1, 3'b000, 1'b0, 5'd9);
    chk("ill.rd", bus.resp_rd, 32'd0);
    chk("ill.flag", 32'(bus.resp_illegal), 32'd1);
    chk("ill.valid", 32'(bus.resp_valid), 32'd1);
    chk("ill.rr_ready", 32'(bus.req_ready), 32'b10);
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    chk("ill.next.rd", bus.resp_rd, 32'd4);
    chk("ill.next.src", 32'(bus.resp_src), 32'd1);
    chk("ill.next.flag", 32'(bus.resp_illegal), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    chk("ill.last.rd", bus.resp_rd, 32'd2);
    chk("ill.last.src", 32'(bus.resp_src), 32'd0);

    // reset while the slot is full and stalled
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1;
    chk("rstfull.pre", 32'(bus.resp_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstfull.valid", 32'(bus.resp_valid), 32'd0);
    chk("rstfull.rd", bus.resp_rd, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.resp_ready = 1'b1;

`ifdef RV_ALU_R_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 3; k++)
      do_op(0, 32'(k), 32'd1, 3'b000, 1'b0, 5'(k),
            32'(k + 1), 1'b0, $sformatf("st0_%0d", k));
    for (int k = 0; k < 2; k++)
      do_op(1, 32'(k), 32'd2, 3'b000, 1'b0, 5'(k),
            32'(k + 2), 1'b0, $sformatf("st1_%0d", k));
    chk("stat.g0", stat_grant0, 32'd3);
    chk("stat.g1", stat_grant1, 32'd2);
    do_reset();
    #1;
    chk("stat.g0_rst", stat_grant0, 32'd0);
    chk("stat.g1_rst", stat_grant1, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
